dfe_rate_ctrl: RTL and testbench
================================

DFE_RATE_CTRL -- requirements
Module: dfe_rate_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_BASE, default 8, meaning the fixed settle length in sample ticks.
REQ-002 The block SHALL have parameter CIC_STAGES, default 3, meaning the CIC stage count used in the settle formula.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 8, meaning the settle counter width.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port sample_tick, input, 1 bit: one-cycle pulse per processing-rate sample (the clkdiv rate).
REQ-007 The block SHALL have port cfg_valid, input, 1 bit: a configuration request is present.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: the block can accept a configuration request.
REQ-009 The block SHALL have port cfg_k, input, 3 bits: requested CIC decimation exponent; legal values are 0..4.
REQ-010 The block SHALL have port cfg_notch_en, input, 1 bit: requested notch-filter enable.
REQ-011 The block SHALL have port filter_enable, output, 1 bit: drives the notch filter enable.
REQ-012 The block SHALL have port CIC_Decimation_Factor, output, 5 bits: drives the CIC decimation factor D = 2^k.
REQ-013 The block SHALL have port out_valid, output, 1 bit: datapath output qualifier; high only when the datapath has settled.
REQ-014 The block SHALL have port busy, output, 1 bit: a reconfiguration is in progress.
REQ-015 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an illegal request is rejected.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, QUIESCE, APPLY, SETTLE.
REQ-017 cfg_ready SHALL be 1 only in IDLE; a request is accepted on a cycle where cfg_valid and cfg_ready are both 1.
REQ-018 On acceptance with cfg_k > 4, cfg_err SHALL pulse for one cycle in the next cycle, and the state and outputs SHALL remain unchanged.
REQ-019 On acceptance of a legal request that matches the current k and notch enable, the FSM SHALL stay in IDLE, with out_valid unaffected and no error.
REQ-020 On acceptance of any other legal request, the FSM SHALL latch cfg_k and cfg_notch_en, go to QUIESCE, and drive out_valid to 0 from the next cycle.
REQ-021 QUIESCE SHALL wait for the first sample_tick strictly after the acceptance cycle; a tick in the acceptance cycle does not count.
REQ-022 That tick SHALL move the FSM to APPLY.
REQ-023 APPLY SHALL last one cycle and update filter_enable and CIC_Decimation_Factor (1 << k) registered at its end.
REQ-024 APPLY SHALL load the settle counter with SETTLE_BASE + (CIC_STAGES << k).
REQ-025 SETTLE SHALL decrement the counter on each sample_tick.
REQ-026 When a tick arrives with the counter at 1, the FSM SHALL go to IDLE and out_valid SHALL rise in the next cycle.
REQ-027 The counter SHALL never wrap; CNT_WIDTH SHALL hold SETTLE_BASE + CIC_STAGES*16, enforced by an elaboration-time check.
REQ-028 busy SHALL be 1 in QUIESCE, APPLY and SETTLE.
REQ-029 cfg_valid SHALL be ignored while busy, and requests SHALL NOT be queued.
REQ-030 filter_enable and CIC_Decimation_Factor SHALL change only at the end of APPLY.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While RST=1 at a clock edge: state SETTLE, counter = SETTLE_BASE + CIC_STAGES, filter_enable 0, CIC_Decimation_Factor 1, out_valid 0, cfg_err 0, cfg_ready 0, busy 1.
REQ-033 After reset the block SHALL count down the k=0 settle length and then enter IDLE.
REQ-034 RST asserted mid-reconfiguration SHALL abandon the latched request and restore the REQ-032 values.
REQ-035 RST SHALL take priority over all other inputs.

Structure
REQ-036 A shared DFE package SHALL hold the FSM state enum, K_MAX=4, and a settle-length function of (SETTLE_BASE, CIC_STAGES, k).
REQ-037 The block SHALL have one natural sub-module, dfe_settle_cnt: a loadable down-counter that counts on tick and flags done.

Verification
REQ-038 Reset then 11 ticks (defaults) -> out_valid stays 0 through the 10th tick, rises the cycle after the 11th, and cfg_ready goes to 1.
REQ-039 In IDLE, request k=3, notch_en=1 -> out_valid drops the next cycle; at the first later tick D=8 and filter_enable=1; out_valid returns after 8+24=32 further ticks.
REQ-040 Request k=5 -> cfg_err pulses once, D and filter_enable are unchanged, out_valid stays 1.
REQ-041 Request equal to the current configuration -> no busy and no out_valid drop.
REQ-042 Request with sample_tick in the same cycle -> APPLY waits for the next tick.
REQ-043 cfg_valid held high during SETTLE, then RST mid-SETTLE -> no second acceptance during SETTLE; the REQ-032 reset values appear one cycle after RST.

Source files
------------

// File: rtl/dfe_rate_ctrl_pkg.sv
// Shared DFE definitions: reconfiguration FSM states, the largest legal
// decimation exponent and the settle-length formula.
package dfe_rate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUIESCE = 2'd1,
    ST_APPLY   = 2'd2,
    ST_SETTLE  = 2'd3
  } dfe_state_e;

  localparam logic [2:0] K_MAX = 3'd4;

  // Settle time in sample ticks: fixed base plus one CIC delay line per
  // stage at the new decimation factor 2^k.
  function automatic int unsigned settle_len(input int unsigned base,
                                             input int unsigned stages,
                                             input logic [2:0]  k);
    return base + (stages << k);
  endfunction

endpackage

// File: rtl/dfe_rate_ctrl_settle_cnt.sv
// Loadable settle down-counter: decrements on each tick, stops at zero and
// flags the tick that expires a count of one.
module dfe_settle_cnt #(
  parameter int unsigned CNT_WIDTH = 8,
  parameter int unsigned RST_VAL   = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 tick,
  output logic                 done
);

  logic [CNT_WIDTH-1:0] count;

  // NOTE: registers are written with <= so every flop samples the values
  // from before the edge; = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= CNT_WIDTH'(RST_VAL);
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = tick && (count == CNT_WIDTH'(1));

endmodule

// File: rtl/dfe_rate_ctrl.sv
// DFE rate controller: accepts CIC decimation / notch reconfiguration
// requests, quiesces the datapath, applies them and waits for it to settle.
module dfe_rate_ctrl
  import dfe_rate_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_BASE = 8,
  parameter int unsigned CIC_STAGES  = 3,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       sample_tick,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_k,
  input  logic       cfg_notch_en,
  output logic       filter_enable,
  output logic [4:0] CIC_Decimation_Factor,
  output logic       out_valid,
  output logic       busy,
  output logic       cfg_err
);

  localparam int unsigned MAX_SETTLE = settle_len(SETTLE_BASE, CIC_STAGES, K_MAX);
  localparam int unsigned RST_SETTLE = settle_len(SETTLE_BASE, CIC_STAGES, 3'd0);

  // The settle counter must hold the longest settle length without wrapping.
  if (CNT_WIDTH < 32 && MAX_SETTLE >= (32'd1 << CNT_WIDTH)) begin : g_cnt_width_check
    $error("dfe_rate_ctrl: CNT_WIDTH too small for the longest settle length");
  end

  dfe_state_e           state;
  dfe_state_e           next_state;
  logic [2:0]           cur_k;
  logic [2:0]           req_k;
  logic                 req_notch;
  logic                 accept;
  logic                 cfg_illegal;
  logic                 cfg_same;
  logic                 start;
  logic                 cnt_done;
  logic [CNT_WIDTH-1:0] load_val;

  assign accept      = cfg_valid && cfg_ready;
  assign cfg_illegal = cfg_k > K_MAX;
  assign cfg_same    = (cfg_k == cur_k) && (cfg_notch_en == filter_enable);
  assign start       = accept && !cfg_illegal && !cfg_same;
  assign load_val    = CNT_WIDTH'(settle_len(SETTLE_BASE, CIC_STAGES, req_k));

  // NOTE: next_state gets its default before the case so every path assigns
  // it; a missing assignment in always_comb would infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (start)       next_state = ST_QUIESCE;
      ST_QUIESCE: if (sample_tick) next_state = ST_APPLY;
      ST_APPLY:                    next_state = ST_SETTLE;
      ST_SETTLE:  if (cnt_done)    next_state = ST_IDLE;
      default:                     next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state                 <= ST_SETTLE;
      cfg_ready             <= 1'b0;
      busy                  <= 1'b1;
      out_valid             <= 1'b0;
      cfg_err               <= 1'b0;
      filter_enable         <= 1'b0;
      CIC_Decimation_Factor <= 5'd1;
      cur_k                 <= 3'd0;
      req_k                 <= 3'd0;
      req_notch             <= 1'b0;
    end else begin
      state     <= next_state;
      cfg_ready <= (next_state == ST_IDLE);
      busy      <= (next_state != ST_IDLE);
      cfg_err   <= accept && cfg_illegal;
      if (state == ST_IDLE && start) begin
        req_k     <= cfg_k;
        req_notch <= cfg_notch_en;
        out_valid <= 1'b0;
      end
      // The datapath sees the new configuration only once it is quiesced.
      if (state == ST_APPLY) begin
        cur_k                 <= req_k;
        filter_enable         <= req_notch;
        CIC_Decimation_Factor <= 5'd1 << req_k;
      end
      if (state == ST_SETTLE && cnt_done) begin
        out_valid <= 1'b1;
      end
    end
  end

  dfe_settle_cnt #(
    .CNT_WIDTH (CNT_WIDTH),
    .RST_VAL   (RST_SETTLE)
  ) u_settle_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (state == ST_APPLY),
    .load_val (load_val),
    .tick     (sample_tick && (state == ST_SETTLE)),
    .done     (cnt_done)
  );

endmodule

// File: tb/tb_dfe_rate_ctrl.sv
// Self-checking bench for dfe_rate_ctrl: reset recovery, a table of
// configuration requests with a completion scoreboard, and reset mid-settle.
module tb_dfe_rate_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       sample_tick = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [2:0] cfg_k = 3'd0;
  logic       cfg_notch_en = 1'b0;
  logic       filter_enable;
  logic [4:0] CIC_Decimation_Factor;
  logic       out_valid;
  logic       busy;
  logic       cfg_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] k;
    logic       notch;
    logic       tick_same;
    logic       exp_err;
    logic       exp_busy;
    logic [4:0] exp_d;
    logic       exp_fe;
    int         exp_ticks;
  } vec_t;

  typedef struct {
    logic [4:0] d;
    logic       fe;
    int         ticks;
  } sb_t;

  vec_t vecs[10];
  sb_t  sb[$];
  sb_t  got;
  vec_t v;
  logic [4:0] cur_d;
  logic       cur_fe;
  int         n;

  dfe_rate_ctrl dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .sample_tick           (sample_tick),
    .cfg_valid             (cfg_valid),
    .cfg_ready             (cfg_ready),
    .cfg_k                 (cfg_k),
    .cfg_notch_en          (cfg_notch_en),
    .filter_enable         (filter_enable),
    .CIC_Decimation_Factor (CIC_Decimation_Factor),
    .out_valid             (out_valid),
    .busy                  (busy),
    .cfg_err               (cfg_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  // One tick pulse followed by two quiet cycles.
  task automatic do_tick();
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
    cycle();
    cycle();
  endtask

  // Ticks until out_valid rises, bounded; result in n.
  task automatic ticks_to_valid();
    n = 0;
    while (!out_valid && n < 200) begin
      do_tick();
      n++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cfg_ready"}, cfg_ready, 0);
    check({tag, "_busy"}, busy, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_cfg_err"}, cfg_err, 0);
    check({tag, "_D"}, CIC_Decimation_Factor, 1);
    check({tag, "_fe"}, filter_enable, 0);
  endtask

  initial begin
    //          k     notch tick  err   busy  D      fe    ticks
    vecs[0] = '{3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8,  1'b1, 32};
    vecs[1] = '{3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8,  1'b1, 0};
    vecs[2] = '{3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8,  1'b1, 0};
    vecs[3] = '{3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 5'd16, 1'b0, 56};
    vecs[4] = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  1'b0, 11};
    vecs[5] = '{3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1,  1'b0, 0};
    vecs[6] = '{3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd2,  1'b1, 14};
    vecs[7] = '{3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2,  1'b0, 14};
    vecs[8] = '{3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2,  1'b0, 0};
    vecs[9] = '{3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4,  1'b1, 20};

    // Reset and recovery through the k=0 settle length.
    RST = 1'b1;
    cycle();
    cycle();
    check_reset_values("reset");
    RST = 1'b0;
    ticks_to_valid();
    check("reset_settle_ticks", n, 11);
    check("reset_ready", cfg_ready, 1);
    check("reset_busy_low", busy, 0);
    cur_d  = 5'd1;
    cur_fe = 1'b0;

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      check($sformatf("v%0d_ready", i), cfg_ready, 1);
      cfg_valid    = 1'b1;
      cfg_k        = v.k;
      cfg_notch_en = v.notch;
      sample_tick  = v.tick_same;
      if (v.exp_busy) sb.push_back('{v.exp_d, v.exp_fe, v.exp_ticks});
      cycle();
      cfg_valid   = 1'b0;
      sample_tick = 1'b0;
      check($sformatf("v%0d_err", i), cfg_err, v.exp_err);
      check($sformatf("v%0d_busy", i), busy, v.exp_busy);
      check($sformatf("v%0d_out_valid", i), out_valid, !v.exp_busy);
      cycle();
      check($sformatf("v%0d_err_pulse_end", i), cfg_err, 0);
      cycle();
      // Still quiesced (or idle): configuration outputs must not have moved.
      check($sformatf("v%0d_D_hold", i), CIC_Decimation_Factor, cur_d);
      check($sformatf("v%0d_fe_hold", i), filter_enable, cur_fe);
      check($sformatf("v%0d_busy_hold", i), busy, v.exp_busy);
      if (v.exp_busy) begin
        do_tick();
        if (sb.size() != 0) begin
          check($sformatf("v%0d_D_applied", i), CIC_Decimation_Factor, sb[0].d);
          check($sformatf("v%0d_fe_applied", i), filter_enable, sb[0].fe);
        end
        ticks_to_valid();
        if (sb.size() == 0) begin
          check($sformatf("v%0d_scoreboard_empty", i), 1, 0);
        end else begin
          got = sb.pop_front();
          check($sformatf("v%0d_settle_ticks", i), n, got.ticks);
          check($sformatf("v%0d_D_final", i), CIC_Decimation_Factor, got.d);
          check($sformatf("v%0d_fe_final", i), filter_enable, got.fe);
          cur_d  = got.d;
          cur_fe = got.fe;
        end
        check($sformatf("v%0d_ready_after", i), cfg_ready, 1);
      end else begin
        check($sformatf("v%0d_out_valid_kept", i), out_valid, 1);
      end
    end

    // cfg_valid held through a reconfiguration, then reset mid-settle.
    cfg_valid    = 1'b1;
    cfg_k        = 3'd2;
    cfg_notch_en = 1'b0;
    cycle();
    check("hold_accept_busy", busy, 1);
    cfg_k = 3'd7;
    do_tick();
    check("hold_D_applied", CIC_Decimation_Factor, 4);
    check("hold_fe_applied", filter_enable, 0);
    for (int t = 0; t < 5; t++) begin
      do_tick();
      check($sformatf("hold_t%0d_state", t),
            {cfg_ready, busy, cfg_err, out_valid}, 4'b0100);
    end
    RST = 1'b1;
    cycle();
    check_reset_values("mid_settle_reset");
    RST       = 1'b0;
    cfg_valid = 1'b0;
    ticks_to_valid();
    check("mid_settle_recover_ticks", n, 11);
    check("mid_settle_recover_D", CIC_Decimation_Factor, 1);
    // After the abandoned request, k=0/notch=0 is the current configuration.
    cfg_valid    = 1'b1;
    cfg_k        = 3'd0;
    cfg_notch_en = 1'b0;
    cycle();
    cfg_valid = 1'b0;
    check("post_reset_same_busy", busy, 0);
    check("post_reset_same_valid", out_valid, 1);

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
